// File: rtl/fifo_drain_if.sv
// Bundle of the FIFO read-side and downstream stream signals of fifo_drain.
// master: the drain block itself; slave: the surrounding FIFO/sink environment.
interface fifo_drain_if #(
    parameter int Width = 8
);
    logic             fifo_empty;
    logic [Width-1:0] fifo_data_out;
    logic             fifo_rd_en;
    logic             flush;
    logic             m_valid;
    logic [Width-1:0] m_data;
    logic             m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_data_out,
        input  flush,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_data_out,
        output flush,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/fifo_drain.sv
// Drains a registered-read FIFO into a valid/ready stream through a 2-entry skid buffer.
// Optional FIFO_DRAIN_STATS_EN adds a 16-bit wrapping accepted-beat counter output.
module fifo_drain_chk #(
    parameter int Width = 8
) (
    input logic             clk,
    input logic             rst_n,
    input logic [1:0]       buf_cnt,
    input logic             load,
    input logic             pop,
    input logic             flush,
    input logic             fifo_empty,
    input logic             fifo_rd_en,
    input logic             m_valid,
    input logic             m_ready,
    input logic [Width-1:0] m_data
);
    // The read-enable throttle must make a load into a full buffer impossible.
    a_no_load_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(load && !pop && (buf_cnt == 2'd2)));

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_rd_en && fifo_empty));

    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        (buf_cnt != 2'd3));

    a_valid_cnt: assert property (@(posedge clk) disable iff (!rst_n)
        (m_valid == (buf_cnt != 2'd0)));

    a_no_rd_on_flush: assert property (@(posedge clk) disable iff (!rst_n)
        !(flush && fifo_rd_en));

    // A stalled beat stays put until accepted or flushed.
    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (m_valid && !m_ready && !flush) |=> (m_valid && $stable(m_data)));
endmodule

module fifo_drain #(
    parameter int Width = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    fifo_drain_if.master        dif
`ifdef FIFO_DRAIN_STATS_EN
    ,
    output logic [15:0]         beat_cnt
`endif
);
    localparam logic [1:0] BUF0 = 2'd0;
    localparam logic [1:0] BUF1 = 2'd1;
    localparam logic [1:0] BUF2 = 2'd2;

    logic [1:0]       buf_cnt_q, buf_cnt_d;
    logic             infl_q, infl_d;
    logic             run_q, run_d;
    logic             m_valid_q, m_valid_d;
    logic [Width-1:0] head_q, head_d;
    logic [Width-1:0] tail_q, tail_d;

    logic             pop_s;
    logic             load_s;
    logic             rd_en_s;
    logic [2:0]       occ_s;

    // Handshake decode; occ_s is the buffer occupancy after this edge if no new read.
    always_comb begin
        pop_s   = (buf_cnt_q != BUF0) && dif.m_ready;
        load_s  = infl_q;
        occ_s   = {1'b0, buf_cnt_q} + {2'b00, infl_q} - {2'b00, pop_s};
        rd_en_s = run_q && !dif.fifo_empty && !dif.flush && (occ_s < 3'd2);
    end

    // run_q keeps reads off until the first edge after reset release.
    always_comb begin
        buf_cnt_d = buf_cnt_q;
        head_d    = head_q;
        tail_d    = tail_q;
        infl_d    = rd_en_s;
        run_d     = 1'b1;
        if (dif.flush) begin
            buf_cnt_d = BUF0;
            infl_d    = 1'b0;
        end else begin
            case (buf_cnt_q)
                BUF0: begin
                    if (load_s) begin
                        head_d    = dif.fifo_data_out;
                        buf_cnt_d = BUF1;
                    end else begin
                        buf_cnt_d = BUF0;
                    end
                end
                BUF1: begin
                    if (load_s && pop_s) begin
                        head_d = dif.fifo_data_out;
                    end else if (load_s) begin
                        tail_d    = dif.fifo_data_out;
                        buf_cnt_d = BUF2;
                    end else if (pop_s) begin
                        buf_cnt_d = BUF0;
                    end else begin
                        buf_cnt_d = BUF1;
                    end
                end
                BUF2: begin
                    // A load without pop cannot arrive here; the throttle forbids it.
                    if (load_s && pop_s) begin
                        head_d = tail_q;
                        tail_d = dif.fifo_data_out;
                    end else if (pop_s) begin
                        head_d    = tail_q;
                        buf_cnt_d = BUF1;
                    end else begin
                        buf_cnt_d = BUF2;
                    end
                end
                default: begin
                    buf_cnt_d = BUF0;
                end
            endcase
        end
        m_valid_d = (buf_cnt_d != BUF0);
    end

    // Buffer state, data registers and the registered valid output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_cnt_q <= BUF0;
            infl_q    <= 1'b0;
            run_q     <= 1'b0;
            m_valid_q <= 1'b0;
            head_q    <= {Width{1'b0}};
            tail_q    <= {Width{1'b0}};
        end else begin
            buf_cnt_q <= buf_cnt_d;
            infl_q    <= infl_d;
            run_q     <= run_d;
            m_valid_q <= m_valid_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
        end
    end

    assign dif.fifo_rd_en = rd_en_s;
    assign dif.m_valid    = m_valid_q;
    assign dif.m_data     = head_q;

`ifdef FIFO_DRAIN_STATS_EN
    logic [15:0] beat_cnt_q, beat_cnt_d;

    // Accepted-beat counter; wraps naturally and is cleared only by reset.
    always_comb begin
        if (pop_s) begin
            beat_cnt_d = beat_cnt_q + 16'd1;
        end else begin
            beat_cnt_d = beat_cnt_q;
        end
    end

    // Beat counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= 16'd0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;
`endif

    fifo_drain_chk #(.Width(Width)) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .buf_cnt    (buf_cnt_q),
        .load       (load_s),
        .pop        (pop_s),
        .flush      (dif.flush),
        .fifo_empty (dif.fifo_empty),
        .fifo_rd_en (rd_en_s),
        .m_valid    (m_valid_q),
        .m_ready    (dif.m_ready),
        .m_data     (head_q)
    );
endmodule

// File: tb/tb_fifo_drain.sv
// Self-checking bench for fifo_drain: vector table, directed corner sequences and a
// randomized run against a queue-based reference model (FIFO_DRAIN_STATS_EN optional).
module tb_fifo_drain;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fifo_drain_if #(.Width(8)) dif ();
`ifdef FIFO_DRAIN_STATS_EN
    logic [15:0] beat_cnt;
`endif

    fifo_drain #(.Width(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dif   (dif)
`ifdef FIFO_DRAIN_STATS_EN
        ,
        .beat_cnt (beat_cnt)
`endif
    );

    typedef struct {
        logic       rdy;
        logic       fl;
        logic       rd;
        logic       mv;
        logic [7:0] data;
    } vec_t;

    // Reference model: upstream FIFO contents, output buffer, in-flight word.
    logic [7:0]  fifo_q[$];
    logic [7:0]  obuf[$];
    logic [7:0]  acc_q[$];
    logic        pend_v;
    logic [7:0]  pend_w;
    logic        run_m;
    logic [15:0] beats_m;
    int          beats_total;

    logic        last_rd, last_mv;
    logic [7:0]  last_data;
    int          vectors;
    int          miscompares;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] acc_at(input int i);
        if (i < acc_q.size()) return acc_q[i];
        return 8'hxx;
    endfunction

    task automatic push(input logic [7:0] w);
        fifo_q.push_back(w);
        dif.fifo_empty = 1'b0;
    endtask

    task automatic model_clear();
        obuf.delete();
        pend_v = 1'b0;
        run_m  = 1'b0;
    endtask

    // One clock cycle: entered and left just after a falling edge.
    task automatic step(input logic rdy, input logic fl);
        logic       exp_mv, exp_rd, pop, got;
        int         occ;
        logic [7:0] w;
        dif.m_ready = rdy;
        dif.flush   = fl;
        #1;
        exp_mv = (obuf.size() > 0);
        pop    = exp_mv && rdy;
        occ    = obuf.size() + (pend_v ? 1 : 0) - (pop ? 1 : 0);
        exp_rd = run_m && (fifo_q.size() > 0) && !fl && (occ < 2);
        last_rd   = dif.fifo_rd_en;
        last_mv   = dif.m_valid;
        last_data = dif.m_data;
        chk("rd_en", 32'(last_rd), 32'(exp_rd));
        chk("m_valid", 32'(last_mv), 32'(exp_mv));
        if (exp_mv) chk("m_data", 32'(last_data), 32'(obuf[0]));
`ifdef FIFO_DRAIN_STATS_EN
        chk("beat_cnt", 32'(beat_cnt), 32'(beats_m));
`endif
        if (last_mv && rdy) acc_q.push_back(last_data);
        @(posedge clk);
        if (pop) begin
            void'(obuf.pop_front());
            beats_m = beats_m + 16'd1;
            beats_total++;
        end
        if (pend_v) obuf.push_back(pend_w);
        if (fl) obuf.delete();
        pend_v = 1'b0;
        got    = 1'b0;
        w      = 8'h00;
        if (last_rd && (fifo_q.size() > 0)) begin
            w      = fifo_q.pop_front();
            got    = 1'b1;
            pend_v = !fl;
            pend_w = w;
        end
        run_m = 1'b1;
        #1;
        if (got) dif.fifo_data_out = w;
        dif.fifo_empty = (fifo_q.size() == 0);
        @(negedge clk);
    endtask

    vec_t tbl[6];

    initial begin
        int rd_cnt;
        vectors     = 0;
        miscompares = 0;
        beats_m     = 16'd0;
        beats_total = 0;
        model_clear();
        rst_n             = 1'b0;
        dif.fifo_empty    = 1'b1;
        dif.fifo_data_out = 8'h00;
        dif.flush         = 1'b0;
        dif.m_ready       = 1'b0;

        // First-word latency and back-to-back streaming of 0x11,0x22,0x33.
        tbl[0] = '{rdy: 1'b1, fl: 1'b0, rd: 1'b1, mv: 1'b0, data: 8'h00};
        tbl[1] = '{rdy: 1'b1, fl: 1'b0, rd: 1'b1, mv: 1'b0, data: 8'h00};
        tbl[2] = '{rdy: 1'b1, fl: 1'b0, rd: 1'b1, mv: 1'b1, data: 8'h11};
        tbl[3] = '{rdy: 1'b1, fl: 1'b0, rd: 1'b0, mv: 1'b1, data: 8'h22};
        tbl[4] = '{rdy: 1'b1, fl: 1'b0, rd: 1'b0, mv: 1'b1, data: 8'h33};
        tbl[5] = '{rdy: 1'b1, fl: 1'b0, rd: 1'b0, mv: 1'b0, data: 8'h00};

        // Reset state, with a word waiting and the sink ready.
        @(negedge clk);
        push(8'h5A);
        dif.m_ready = 1'b1;
        #1;
        chk("rst_rd_en", 32'(dif.fifo_rd_en), 32'd0);
        chk("rst_m_valid", 32'(dif.m_valid), 32'd0);
        chk("rst_m_data", 32'(dif.m_data), 32'd0);
        @(negedge clk);
        void'(fifo_q.pop_front());
        dif.fifo_empty = 1'b1;
        rst_n = 1'b1;
        step(1'b0, 1'b0);

        push(8'h11); push(8'h22); push(8'h33);
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].rdy, tbl[i].fl);
            chk("tbl_rd_en", 32'(last_rd), 32'(tbl[i].rd));
            chk("tbl_m_valid", 32'(last_mv), 32'(tbl[i].mv));
            if (tbl[i].mv) chk("tbl_m_data", 32'(last_data), 32'(tbl[i].data));
        end

        // Stalled sink: exactly two reads, first word held, nothing lost on release.
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        acc_q.delete();
        rd_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            rd_cnt += int'(last_rd);
            if (i >= 2) chk("stall_hold", 32'({last_mv, last_data}), 32'({1'b1, 8'hA1}));
        end
        chk("stall_rd_pulses", 32'(rd_cnt), 32'd2);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        chk("stall_beats", 32'(acc_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("stall_order", 32'(acc_at(i)), 32'(8'hA1 + 8'(i)));

        // Empty FIFO with a random sink never reads and never presents data.
        for (int i = 0; i < 30; i++) begin
            step(1'($urandom_range(0, 1)), 1'b0);
            chk("empty_quiet", 32'({last_rd, last_mv}), 32'd0);
        end

        // Flush in BUF2: buffer emptied, stream resumes from the next FIFO word.
        push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        acc_q.delete();
        step(1'b0, 1'b0);
        chk("flush_buf2_valid", 32'(last_mv), 32'd0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        chk("flush_buf2_beats", 32'(acc_q.size()), 32'd2);
        chk("flush_buf2_next", 32'(acc_at(0)), 32'h0B3);

        // Flush with a word in flight: that word must never reach m_data.
        push(8'hC1); push(8'hC2); push(8'hC3);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("flush_infl_rd", 32'(last_rd), 32'd0);
        acc_q.delete();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        chk("flush_infl_beats", 32'(acc_q.size()), 32'd2);
        chk("flush_infl_first", 32'(acc_at(0)), 32'h0C2);
        chk("flush_infl_second", 32'(acc_at(1)), 32'h0C3);

        // Reset mid-transfer (BUF1 + in flight): outputs drop before the next edge.
        push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4); push(8'hD5);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        dif.m_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(dif.m_valid), 32'd0);
        chk("async_rst_rd_en", 32'(dif.fifo_rd_en), 32'd0);
        chk("async_rst_data", 32'(dif.m_data), 32'd0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        acc_q.delete();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        chk("rst_resume_beats", 32'(acc_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) chk("rst_resume_order", 32'(acc_at(i)), 32'(8'hD3 + 8'(i)));

        // Randomized traffic with occasional flushes against the model.
        for (int i = 0; i < 1200; i++) begin
            if ((fifo_q.size() < 5) && ($urandom_range(0, 2) != 0)) push(8'($urandom_range(0, 255)));
            if (i < 400)      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0));
            else if (i < 800) step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 29) == 0));
            else              step(1'b1, 1'($urandom_range(0, 59) == 0));
        end

`ifdef FIFO_DRAIN_STATS_EN
        // 65537 accepted beats from reset leave the counter at 1.
        rst_n = 1'b0;
        fifo_q.delete();
        dif.fifo_empty = 1'b1;
        model_clear();
        beats_m     = 16'd0;
        beats_total = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            if (beats_total >= 65537) break;
            if (fifo_q.size() < 4) push(8'(i));
            step(1'b1, 1'b0);
        end
        chk("stats_total", 32'(beats_total), 32'd65537);
        chk("stats_wrap", 32'(beat_cnt), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
